// File: rtl/demux4bit_stream_pkg.sv
// Shared types and constants for the 4-bit stream demultiplexer and its
// per-channel 2-entry buffers.
package demux4bit_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam int   DEPTH = 2;
  localparam logic CH_A  = 1'b0;
  localparam logic CH_B  = 1'b1;

  function automatic int occupancy(input buf_state_e st);
    case (st)
      ONE:     return 1;
      TWO:     return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/demux4bit_fifo2.sv
// Two-entry W-wide buffer with registered head; push while full is dropped,
// pop while empty is ignored, push+pop with one entry replaces the head.
module demux4bit_fifo2
  import demux4bit_stream_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] head
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push = push && (occupancy(state_q) < DEPTH);
    do_pop  = pop && (state_q != EMPTY);
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (do_push) begin
          head_d  = din;
          state_d = ONE;
        end
      end
      ONE: begin
        if (do_push && do_pop) begin
          head_d = din;
        end else if (do_push) begin
          tail_d  = din;
          state_d = TWO;
        end else if (do_pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // no bypass when full: the producer is already stalled this cycle
        if (do_pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign full  = (occupancy(state_q) == DEPTH);
  assign valid = (state_q != EMPTY);
  assign head  = head_q;

endmodule

// File: rtl/demux4bit_stream.sv
// Routes one valid/ready nibble stream to channel A or B per beat, each
// channel buffered two deep, with wrapping per-channel accepted-beat counters.
module demux4bit_stream
  import demux4bit_stream_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i,
  input  logic             i_valid,
  input  logic             s,
  output logic             i_ready,
  output logic [W-1:0]     a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [W-1:0]     b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic             full_a, full_b;
  logic             accept, push_a, push_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // ready depends only on the selected channel, so a full A never stalls B traffic
  always_comb begin
    i_ready = (s == CH_B) ? !full_b : !full_a;
    accept  = i_valid && i_ready;
    push_a  = accept && (s == CH_A);
    push_b  = accept && (s == CH_B);
    cnt_a_d = cnt_a_q + CNT_W'(push_a);
    cnt_b_d = cnt_b_q + CNT_W'(push_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  demux4bit_fifo2 #(.W(W)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .pop   (a_ready),
    .din   (i),
    .full  (full_a),
    .valid (a_valid),
    .head  (a)
  );

  demux4bit_fifo2 #(.W(W)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .pop   (b_ready),
    .din   (i),
    .full  (full_b),
    .valid (b_valid),
    .head  (b)
  );

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule
